mem_rr_arbiter: RTL and testbench

- Three-requester round-robin arbiter sharing the single physical-memory port between the I-cache (port 0), the D-cache (port 1) and the eviction write buffer (port 2).
- Sits between the cache hierarchy and physical memory.
- Latches the winning request into registers so memory sees stable address, data and command for the whole transaction.
- Rotates priority after every completed transaction, and flags a hung memory through a watchdog.

---
 rtl/lc3b_types.sv | 28 ++
 rtl/rr_priority_pick.sv | 40 ++++
 rtl/mem_rr_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the lc3b memory-side arbitration logic.
// Contents: arbiter state encoding, fixed requester indices, index width,
// and the round-robin pointer advance helper.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int ARB_IDX_ICACHE = 0;
    localparam int ARB_IDX_DCACHE = 1;
    localparam int ARB_IDX_EWB    = 2;

    // Requester index width; covers up to four requesters.
    localparam int IDX_W = 2;

    // Pointer to the requester after idx, wrapping at n_req.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                                 input int n_req);
        if (int'(idx) >= n_req - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
// Ports:
//   active    in  N_REQ  requester active vector
//   rr_ptr    in  2      index holding highest priority
//   winner    out 2      first active index at or above rr_ptr (wrapping)
//   any_valid out 1      at least one requester active
module rr_priority_pick
    import lc3b_types::*;
#(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] active,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    function automatic logic [IDX_W-1:0] cand(input logic [IDX_W-1:0] ptr,
                                              input int off);
        int s;
        s = int'(ptr) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Walk from the farthest offset down to rr_ptr itself so the nearest
    // active requester is the last (and final) assignment.
    always_comb begin
        winner    = '0;
        any_valid = |active;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (active[cand(rr_ptr, off)]) begin
                winner = cand(rr_ptr, off);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache
// (0), D-cache (1) and eviction write buffer (2). The winning request is
// latched so memory sees stable command/address/data for the whole
// transaction; priority rotates after each completion; a watchdog flags a
// memory that never responds.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_read/req_write      per-requester strobes, held until req_resp
//   req_addr/req_wdata      packed per-requester address / write line
//   req_resp                one-hot completion pulse to the granted requester
//   req_rdata               read line, valid only with req_resp
//   mem_read/mem_write      memory command (from latched op)
//   mem_addr/mem_wdata      latched address / write line
//   mem_resp/mem_rdata      memory completion pulse and read data
//   busy                    transaction in flight
//   grant_idx               current or last granted requester
//   timeout_err             sticky watchdog flag
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate among active requesters, latch winner on the edge
// BUSY  | command presented to memory, waiting for mem_resp
// DONE  | one-cycle bubble so the served requester can drop its request
module mem_rr_arbiter
    import lc3b_types::*;
#(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_read,
    input  logic [N_REQ-1:0]         req_write,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*LINE_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         req_resp,
    output logic [LINE_W-1:0]        req_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic                     mem_resp,
    input  logic [LINE_W-1:0]        mem_rdata,
    output logic                     busy,
    output logic [1:0]               grant_idx,
    output logic                     timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    arb_state_t        state_q,  state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_q,  grant_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [LINE_W-1:0] wdata_q,  wdata_d;
    logic              op_rd_q,  op_rd_d;
    logic              op_wr_q,  op_wr_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              err_q,    err_d;

    logic [N_REQ-1:0]  active;
    logic [IDX_W-1:0]  win;
    logic              any_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_wdata;
    logic              sel_rd;
    logic              sel_wr;
    logic              resp_fire;

    assign active = req_read | req_write;

    rr_priority_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .active    (active),
        .rr_ptr    (rr_ptr_q),
        .winner    (win),
        .any_valid (any_valid)
    );

    // Mux out the winner's request; read+write together is a write.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IDX_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*LINE_W +: LINE_W];
                sel_wr    = req_write[i];
                sel_rd    = req_read[i] & ~req_write[i];
            end
        end
    end

    assign resp_fire = (state_q == BUSY) && mem_resp;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        op_rd_d  = op_rd_q;
        op_wr_d  = op_wr_q;
        wd_cnt_d = wd_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d  = BUSY;
                    grant_d  = win;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    op_rd_d  = sel_rd;
                    op_wr_d  = sel_wr;
                    wd_cnt_d = '0;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    state_d  = DONE;
                    rr_ptr_d = rr_next(grant_q, N_REQ);
                end else if (wd_cnt_q != WD_W'(TIMEOUT)) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Sticky; the transaction itself is never aborted.
        err_d = err_q | (wd_cnt_d == WD_W'(TIMEOUT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            op_rd_q  <= 1'b0;
            op_wr_q  <= 1'b0;
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            op_rd_q  <= op_rd_d;
            op_wr_q  <= op_wr_d;
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    // Commands drop in the completion cycle so memory does not see a
    // second request before the FSM leaves BUSY.
    assign busy        = (state_q == BUSY);
    assign mem_read    = busy && op_rd_q && !mem_resp;
    assign mem_write   = busy && op_wr_q && !mem_resp;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign grant_idx   = grant_q;
    assign timeout_err = err_q;
    assign req_rdata   = resp_fire ? mem_rdata : '0;

    always_comb begin
        req_resp = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (resp_fire && (grant_q == IDX_W'(i))) begin
                req_resp[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_read;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*LINE_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_resp;
    logic [LINE_W-1:0]       req_rdata;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_W-1:0]       mem_addr;
    logic [LINE_W-1:0]       mem_wdata;
    logic                    mem_resp;
    logic [LINE_W-1:0]       mem_rdata;
    logic                    busy;
    logic [1:0]              grant_idx;
    logic                    timeout_err;

    int n_total = 0;
    int n_pass  = 0;

    logic [127:0] pat_a5;
    logic [127:0] pat_beef;

    mem_rr_arbiter #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_resp    (req_resp),
        .req_rdata   (req_rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .grant_idx   (grant_idx),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Called in an IDLE cycle with requests already driven; memory answers
    // in the lat-th BUSY cycle. Returns in the following IDLE cycle.
    task automatic serve(input logic [1:0] exp_idx, input int lat, input string tag);
        logic [2:0] exp_resp;
        exp_resp = 3'b001 << exp_idx;
        cyc();
        chk({tag, "_grant"}, grant_idx, exp_idx);
        chk({tag, "_busy"}, busy, 1'b1);
        repeat (lat - 1) cyc();
        mem_resp = 1'b1;
        #1;
        chk({tag, "_resp"}, req_resp, exp_resp);
        cyc();
        mem_resp = 1'b0;
        #1;
        chk({tag, "_done_busy"}, busy, 1'b0);
        cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        pat_a5    = {16{8'hA5}};
        pat_beef  = {4{32'hDEADBEEF}};
        rst_n     = 1'b0;
        req_read  = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_resp  = 1'b0;
        mem_rdata = '0;

        // Reset values
        repeat (2) cyc();
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_grant", grant_idx, 2'd0);
        chk("rst_timeout", timeout_err, 1'b0);
        chk("rst_resp", req_resp, 3'b000);
        #3;
        rst_n = 1'b1;

        // 1. Single read from requester 0
        cyc();
        req_read = 3'b001;
        req_addr[0*ADDR_W +: ADDR_W] = 16'h1230;
        #1;
        chk("t1_idle_mem_read", mem_read, 1'b0);
        cyc();
        chk("t1_mem_read", mem_read, 1'b1);
        chk("t1_mem_write", mem_write, 1'b0);
        chk("t1_mem_addr", mem_addr, 16'h1230);
        chk("t1_busy", busy, 1'b1);
        chk("t1_no_resp", req_resp, 3'b000);
        cyc();
        mem_resp  = 1'b1;
        mem_rdata = pat_a5;
        #1;
        chk("t1_resp", req_resp, 3'b001);
        chk("t1_rdata", req_rdata, pat_a5);
        chk("t1_cmd_drop", mem_read, 1'b0);
        cyc();
        req_read = 3'b000;
        #1;
        chk("t1_done_busy", busy, 1'b0);
        chk("t1_done_resp_ign", req_resp, 3'b000);
        chk("t1_done_rdata", req_rdata, 128'h0);
        mem_resp = 1'b0;
        cyc();
        chk("t1_idle_busy", busy, 1'b0);
        mem_resp = 1'b1;
        #1;
        chk("t1_idle_resp_ign", req_resp, 3'b000);
        mem_resp = 1'b0;

        // 2. All three requesting: order 0,1,2,0
        do_reset();
        cyc();
        req_read = 3'b111;
        serve(2'd0, 2, "t2_a");
        serve(2'd1, 2, "t2_b");
        serve(2'd2, 2, "t2_c");
        serve(2'd0, 2, "t2_d");
        req_read = 3'b000;
        cyc();
        chk("t2_idle", busy, 1'b0);

        // 3. Read+write on requester 2 is a write (rr_ptr now 1)
        req_read  = 3'b100;
        req_write = 3'b100;
        req_addr[2*ADDR_W +: ADDR_W]  = 16'h3FFE;
        req_wdata[2*LINE_W +: LINE_W] = pat_beef;
        cyc();
        chk("t3_grant", grant_idx, 2'd2);
        chk("t3_mem_write", mem_write, 1'b1);
        chk("t3_mem_read", mem_read, 1'b0);
        chk("t3_wdata", mem_wdata, pat_beef);
        chk("t3_addr", mem_addr, 16'h3FFE);
        mem_resp = 1'b1;
        #1;
        chk("t3_resp", req_resp, 3'b100);
        chk("t3_cmd_drop", mem_write, 1'b0);
        cyc();
        mem_resp  = 1'b0;
        req_read  = 3'b000;
        req_write = 3'b000;
        cyc();

        // 4. Latched request survives input changes (rr_ptr now 0)
        req_read = 3'b010;
        req_addr[1*ADDR_W +: ADDR_W] = 16'h00F0;
        cyc();
        chk("t4_grant", grant_idx, 2'd1);
        req_addr[1*ADDR_W +: ADDR_W] = 16'h0F00;
        req_read = 3'b000;
        #1;
        chk("t4_addr_a", mem_addr, 16'h00F0);
        cyc();
        chk("t4_addr_b", mem_addr, 16'h00F0);
        chk("t4_mem_read", mem_read, 1'b1);
        mem_resp = 1'b1;
        #1;
        chk("t4_resp", req_resp, 3'b010);
        cyc();
        mem_resp = 1'b0;
        cyc();
        cyc();
        chk("t4_no_regrant", busy, 1'b0);

        // 5. Watchdog (TIMEOUT = 8), rr_ptr now 2
        req_read = 3'b001;
        req_addr[0*ADDR_W +: ADDR_W] = 16'h0042;
        cyc();
        chk("t5_grant", grant_idx, 2'd0);
        req_read = 3'b000;
        repeat (6) cyc();
        chk("t5_err_early", timeout_err, 1'b0);
        repeat (2) cyc();
        chk("t5_err_set", timeout_err, 1'b1);
        chk("t5_still_busy", busy, 1'b1);
        mem_resp = 1'b1;
        #1;
        chk("t5_resp", req_resp, 3'b001);
        cyc();
        mem_resp = 1'b0;
        cyc();
        chk("t5_err_sticky", timeout_err, 1'b1);

        // 6. Async reset mid-transaction (rr_ptr now 1)
        req_read = 3'b100;
        cyc();
        chk("t6_pre_read", mem_read, 1'b1);
        chk("t6_pre_grant", grant_idx, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_read", mem_read, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_err", timeout_err, 1'b0);
        chk("t6_rst_grant", grant_idx, 2'd0);
        chk("t6_rst_addr", mem_addr, 16'h0);
        #1;
        rst_n = 1'b1;
        req_read = 3'b110;
        cyc();
        chk("t6_regrant", grant_idx, 2'd1);
        chk("t6_busy", busy, 1'b1);
        mem_resp = 1'b1;
        #1;
        chk("t6_resp", req_resp, 3'b010);
        cyc();
        mem_resp = 1'b0;
        req_read = 3'b000;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
